// File: rtl/conv_scheduler.sv
// Sliding-window scheduler: walks every valid kernel origin of an IMGHEIGHT x IMGWIDTH map
// under downstream backpressure and tracks kernel results through a KLAT-deep valid/address pipe.
module conv_scheduler #(
    parameter int IMGHEIGHT    = 8,
    parameter int IMGWIDTH     = 8,
    parameter int FILTERHEIGHT = 3,
    parameter int FILTERWIDTH  = 3,
    parameter int KLAT         = 1,
    parameter int AW           = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          out_ready,
    output logic          win_valid,
    output logic [AW-1:0] win_row,
    output logic [AW-1:0] win_col,
    output logic          res_valid,
    output logic [AW-1:0] res_addr,
    output logic          busy,
    output logic          done
);

    localparam int OH = IMGHEIGHT - FILTERHEIGHT + 1;
    localparam int OW = IMGWIDTH - FILTERWIDTH + 1;
    localparam logic [AW-1:0] LAST_ROW  = AW'(OH - 1);
    localparam logic [AW-1:0] LAST_COL  = AW'(OW - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(OH * OW - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state, state_nxt;
    logic [AW-1:0]       iss_addr;
    logic                last_win;
    logic [KLAT:1]       vld_pipe;
    logic [KLAT:1][AW-1:0] addr_pipe;

    assign last_win  = (win_row == LAST_ROW) && (win_col == LAST_COL);
    assign res_valid = vld_pipe[KLAT];
    assign res_addr  = addr_pipe[KLAT];

    always_comb begin
        state_nxt = state;
        win_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN: begin
                busy      = 1'b1;
                win_valid = out_ready;
                if (out_ready && last_win) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                // addresses come out in issue order, so the final address marks the end
                if (res_valid && res_addr == LAST_ADDR) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            win_row  <= '0;
            win_col  <= '0;
            iss_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                win_row  <= '0;
                win_col  <= '0;
                iss_addr <= '0;
            end else if (win_valid && !last_win) begin
                iss_addr <= iss_addr + 1'b1;
                if (win_col == LAST_COL) begin
                    win_col <= '0;
                    win_row <= win_row + 1'b1;
                end else begin
                    win_col <= win_col + 1'b1;
                end
            end
        end
    end

    // result pipe advances every cycle, independent of out_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
        end else begin
            for (int i = KLAT; i > 1; i--) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
            vld_pipe[1]  <= win_valid;
            addr_pipe[1] <= iss_addr;
        end
    end

endmodule

// File: tb/tb_conv_scheduler.sv
// Directed bench for conv_scheduler: default map, KLAT=3 map and a 3x3 single-window map.
module tb_conv_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       rdy;
    logic [2:0] st;
    logic [2:0] wv, rv, bz, dn;
    logic [7:0] wr [3];
    logic [7:0] wc [3];
    logic [7:0] ra [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    conv_scheduler #(.KLAT(1)) dut0 (
        .clk(clk), .rst(rst), .start(st[0]), .out_ready(rdy),
        .win_valid(wv[0]), .win_row(wr[0]), .win_col(wc[0]),
        .res_valid(rv[0]), .res_addr(ra[0]), .busy(bz[0]), .done(dn[0]));

    conv_scheduler #(.KLAT(3)) dut1 (
        .clk(clk), .rst(rst), .start(st[1]), .out_ready(rdy),
        .win_valid(wv[1]), .win_row(wr[1]), .win_col(wc[1]),
        .res_valid(rv[1]), .res_addr(ra[1]), .busy(bz[1]), .done(dn[1]));

    conv_scheduler #(.IMGHEIGHT(3), .IMGWIDTH(3), .KLAT(1)) dut2 (
        .clk(clk), .rst(rst), .start(st[2]), .out_ready(rdy),
        .win_valid(wv[2]), .win_row(wr[2]), .win_col(wc[2]),
        .res_valid(rv[2]), .res_addr(ra[2]), .busy(bz[2]), .done(dn[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_idle(input int s, input string tag);
        chk({tag, ".win_valid"}, 32'(wv[s]), 0);
        chk({tag, ".busy"},      32'(bz[s]), 0);
        chk({tag, ".done"},      32'(dn[s]), 0);
        chk({tag, ".res_valid"}, 32'(rv[s]), 0);
    endtask

    // mode 0: ready always; 1: ready on even cycles; 2: ready always, start spammed in RUN and DONE
    task automatic run_pass(input int s, input int oh, input int ow, input int k, input int mode);
        int  total, n_iss, n_res, done_cycle;
        bit  finished, exp_rv;
        bit  hv [0:1023];
        int  ha [0:1023];
        total = oh * ow; n_iss = 0; n_res = 0; done_cycle = -1; finished = 0;
        @(negedge clk);
        st[s] = 1'b1; rdy = 1'b1;
        #1 chk_idle(s, "pre_start");
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            st[s] = (mode == 2) && (c == 3 || c == done_cycle);
            rdy   = (mode == 1) ? (c % 2 == 0) : 1'b1;
            #1;
            hv[c] = 1'b0; ha[c] = 0;
            if (n_iss < total) begin
                chk("run.win_valid", 32'(wv[s]), 32'(rdy));
                chk("run.win_row", 32'(wr[s]), 32'(n_iss / ow));
                chk("run.win_col", 32'(wc[s]), 32'(n_iss % ow));
                if (rdy) begin hv[c] = 1'b1; ha[c] = n_iss; n_iss++; end
            end else begin
                chk("drain.win_valid", 32'(wv[s]), 0);
                if (c != done_cycle) begin
                    chk("drain.hold_row", 32'(wr[s]), 32'(oh - 1));
                    chk("drain.hold_col", 32'(wc[s]), 32'(ow - 1));
                end
            end
            exp_rv = (c >= k) ? hv[c-k] : 1'b0;
            chk("res_valid", 32'(rv[s]), 32'(exp_rv));
            if (exp_rv) begin
                chk("res_addr", 32'(ra[s]), 32'(ha[c-k]));
                n_res++;
                if (ha[c-k] == total - 1) done_cycle = c + 1;
            end
            chk("done", 32'(dn[s]), 32'(c == done_cycle));
            chk("busy", 32'(bz[s]), 32'(c != done_cycle));
            if (c == done_cycle) begin finished = 1'b1; break; end
        end
        chk("pass_finished", 32'(finished), 1);
        chk("result_count", 32'(n_res), 32'(total));
        @(negedge clk);
        st[s] = 1'b0;
        #1 chk_idle(s, "post_pass");
        @(negedge clk);
        #1 chk_idle(s, "post_pass2");
    endtask

    initial begin
        rst = 1'b1; st = '0; rdy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            chk_idle(s, "reset");
            chk("reset.win_row", 32'(wr[s]), 0);
            chk("reset.win_col", 32'(wc[s]), 0);
            chk("reset.res_addr", 32'(ra[s]), 0);
        end

        run_pass(0, 6, 6, 1, 0);
        run_pass(0, 6, 6, 1, 1);
        run_pass(1, 6, 6, 3, 0);
        run_pass(1, 6, 6, 3, 1);
        run_pass(0, 6, 6, 1, 2);

        // abort after the 10th issue
        @(negedge clk);
        st[0] = 1'b1; rdy = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (9) @(negedge clk);
        #1 chk("abort.pre_col", 32'(wc[0]), 3);
        chk("abort.pre_row", 32'(wr[0]), 1);
        @(negedge clk);
        rst = 1'b1; rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0; rdy = 1'b1;
        #1 chk_idle(0, "abort");
        chk("abort.win_row", 32'(wr[0]), 0);
        chk("abort.win_col", 32'(wc[0]), 0);
        chk("abort.res_addr", 32'(ra[0]), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk_idle(0, "abort_after");
        end
        run_pass(0, 6, 6, 1, 0);

        run_pass(2, 1, 1, 1, 0);
        run_pass(2, 1, 1, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
